// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data is preferred, bounded by a streak limit; a watchdog aborts stuck accesses.
module cpu_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT         = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req,
   input  logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  instr_ack,
   output logic [31:0]           instr_rdata,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [31:0]           data_wdata,
   input  logic [3:0]            data_be,
   output logic                  data_ack,
   output logic [31:0]           data_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } state_t;

   localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);
   localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

   state_t     state;
   logic [2:0] streak;
   logic [7:0] wdog;
   logic       pick_d;
   logic       pick_i;
   logic       expire;
   logic       finish;

   always_comb begin
      pick_d = data_req && (!instr_req || (streak < STREAK_MAX));
      pick_i = instr_req && !pick_d;
      // expiry means this cycle would be the TIMEOUT-th unanswered one
      expire = !mem_ready && (wdog == WDOG_LAST);
      finish = mem_ready || expire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         streak      <= 3'd0;
         wdog        <= 8'd0;
         instr_ack   <= 1'b0;
         instr_rdata <= 32'h0;
         data_ack    <= 1'b0;
         data_rdata  <= 32'h0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 32'h0;
         mem_be      <= 4'h0;
         timeout_err <= 1'b0;
      end else begin
         instr_ack <= 1'b0;
         data_ack  <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  pick_d: begin
                     state     <= GRANT_D;
                     wdog      <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= data_we;
                     mem_addr  <= data_addr;
                     mem_wdata <= data_wdata;
                     mem_be    <= data_be;
                     if (!instr_req)
                        streak <= 3'd0;
                     else if (streak != 3'd7)
                        streak <= streak + 3'd1;
                  end
                  pick_i: begin
                     state     <= GRANT_I;
                     wdog      <= 8'd0;
                     streak    <= 3'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= instr_addr;
                     mem_wdata <= 32'h0;
                     mem_be    <= 4'hF;
                  end
                  default: ;
               endcase
            end
            GRANT_I, GRANT_D: begin
               if (finish) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= 32'h0;
                  mem_be    <= 4'h0;
                  if (!mem_ready)
                     timeout_err <= 1'b1;
                  if (state == GRANT_I) begin
                     instr_ack   <= 1'b1;
                     instr_rdata <= mem_ready ? mem_rdata : 32'h0;
                  end else begin
                     data_ack   <= 1'b1;
                     data_rdata <= mem_ready ? mem_rdata : 32'h0;
                  end
               end else begin
                  wdog <= wdog + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
